salamander_prom_loader: RTL and testbench
=========================================

SALAMANDER_PROM_LOADER -- requirements
Module: salamander_prom_loader

Interface
REQ-001 SHALL have parameter AW, default 16, download address width.
REQ-002 SHALL have parameter NREG, default 4, number of PROM regions (1..8).
REQ-003 SHALL have parameter RAW, default 10, region address width; region size 2**RAW bytes.
REQ-004 SHALL have parameter BASE, default 0, download address of region 0 byte 0.
REQ-005 SHALL have one clock and asynchronous active-high reset:
- i_MCLK  in  1  clock
- i_RST  in  1  reset
REQ-006 SHALL have the download-side ports:
- i_DL_START  in  1  pulse, begin download
- i_DL_END  in  1  pulse, end download
- i_DL_WR  in  1  byte strobe
- i_DL_ADDR  in  AW  byte address
- i_DL_DATA  in  8  byte data
- o_DL_WAIT  out  1  backpressure
REQ-007 SHALL have the PROM-side ports:
- o_PROG_ADDR  out  RAW  region byte address
- o_PROG_DIN  out  8  write data
- o_PROG_CS  out  NREG  one-hot region select
- o_PROG_WR  out  1  write strobe
REQ-008 SHALL have the status and check ports:
- o_BUSY  out  1  load in progress
- o_DONE  out  1  load complete
- o_ERR  out  1  error sticky
- o_COUNT  out  AW  bytes written
- i_EXP_SUM  in  8  expected checksum

Function
REQ-009 SHALL implement states IDLE, LOAD, WRITE, DONE.
REQ-010 SHALL move IDLE->LOAD or DONE->LOAD on i_DL_START; entry SHALL clear o_COUNT, checksum and o_ERR.
REQ-011 SHALL, in LOAD, compute off = i_DL_ADDR - BASE on an i_DL_WR cycle; an in-range byte (BASE <= addr < BASE + NREG*2**RAW) SHALL latch addr/data, set o_DL_WAIT next cycle and enter WRITE.
REQ-012 SHALL discard out-of-range bytes: no write, no wait, no count, no checksum, state stays LOAD.
REQ-013 SHALL, in WRITE, drive o_PROG_WR=1 and o_PROG_CS bit off[RAW+2:RAW] for exactly one cycle, with o_PROG_ADDR=off[RAW-1:0] and o_PROG_DIN=latched byte.
REQ-014 SHALL, in WRITE, increment o_COUNT (wraps at 2**AW) and add the byte to an 8-bit checksum mod 256, then return to LOAD with o_DL_WAIT=0.
REQ-015 SHALL give one accepted byte per 2 cycles; o_DL_WAIT SHALL be high only during WRITE.
REQ-016 SHALL treat i_DL_WR while o_DL_WAIT=1 as a protocol violation: byte dropped, o_ERR set.
REQ-017 SHALL move LOAD->DONE on i_DL_END; i_DL_END in WRITE or coincident with an accepted i_DL_WR SHALL complete that write first, then enter DONE.
REQ-018 SHALL ignore i_DL_END in IDLE or DONE, and ignore i_DL_START in LOAD or WRITE.
REQ-019 SHALL hold o_BUSY=1 in LOAD and WRITE only, and o_DONE=1 in DONE only.
REQ-020 SHALL hold o_PROG_CS=0 and o_PROG_WR=0 outside WRITE.

Reset
REQ-021 SHALL, on i_RST, immediately enter IDLE with all outputs 0, including o_DL_WAIT, o_PROG_CS, o_PROG_WR, o_COUNT and o_ERR.
REQ-022 SHALL abort a write in progress on reset mid-WRITE, with o_PROG_WR=0 asynchronously; no partial state SHALL survive.

Configuration
REQ-023 With macro SALAMANDER_PROM_CHECKSUM_EN defined, entry to DONE SHALL compare the checksum with i_EXP_SUM and set o_ERR on mismatch.
REQ-024 Without SALAMANDER_PROM_CHECKSUM_EN, no checksum logic SHALL exist, i_EXP_SUM SHALL be ignored, and o_ERR SHALL reflect REQ-016 only.

Verification
REQ-025 Defaults: START, bytes 0x11/0x22 at addr 0x0000/0x0401, END -> CS=0001 addr 0x000 din 0x11; CS=0010 addr 0x001 din 0x22; o_COUNT=2, o_DONE=1.
REQ-026 Addr 0x1000 (out of range), data 0xAA -> no PROG_WR, o_DL_WAIT stays 0, o_COUNT=0.
REQ-027 DL_WR on consecutive cycles -> second byte dropped, o_ERR=1, one write.
REQ-028 DL_WR and DL_END same cycle (addr 0x0C05, data 0x5A) -> CS=1000 addr 0x005 write, then o_DONE=1.
REQ-029 i_RST asserted during WRITE -> o_PROG_WR=0 and o_BUSY=0 without waiting for a clock edge; next START loads cleanly.
REQ-030 With SALAMANDER_PROM_CHECKSUM_EN, bytes 0x80,0x81, i_EXP_SUM=0x01 -> o_ERR=0; i_EXP_SUM=0x02 -> o_ERR=1.

Source files
------------

// File: rtl/salamander_prom_loader.sv
// Download-to-PROM loader: steers a byte-serial download stream into NREG
// one-hot-selected PROM regions of 2**RAW bytes each. Every accepted byte
// takes two cycles (LOAD accept, WRITE strobe); o_DL_WAIT applies backpressure
// during the strobe cycle.
//
// Ports
//   i_MCLK, i_RST             clock, asynchronous active-high reset
//   i_DL_START / i_DL_END     download begin / end pulses
//   i_DL_WR, i_DL_ADDR,       byte strobe, byte address, byte data
//   i_DL_DATA
//   o_DL_WAIT                 high while a byte is being written
//   o_PROG_ADDR/DIN/CS/WR     region byte address, data, region select, strobe
//   o_BUSY, o_DONE            load in progress / load complete
//   o_ERR                     sticky error (protocol violation, checksum)
//   o_COUNT                   bytes written since the last start
//   i_EXP_SUM                 expected 8-bit checksum
//
// Build option: define SALAMANDER_PROM_CHECKSUM_EN to compare the running
// checksum against i_EXP_SUM when the load completes.
module salamander_prom_loader #(
    parameter int unsigned AW   = 16,
    parameter int unsigned NREG = 4,
    parameter int unsigned RAW  = 10,
    parameter int unsigned BASE = 0
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_DL_START,
    input  logic              i_DL_END,
    input  logic              i_DL_WR,
    input  logic [AW-1:0]     i_DL_ADDR,
    input  logic [7:0]        i_DL_DATA,
    output logic              o_DL_WAIT,
    output logic [RAW-1:0]    o_PROG_ADDR,
    output logic [7:0]        o_PROG_DIN,
    output logic [NREG-1:0]   o_PROG_CS,
    output logic              o_PROG_WR,
    output logic              o_BUSY,
    output logic              o_DONE,
    output logic              o_ERR,
    output logic [AW-1:0]     o_COUNT,
    input  logic [7:0]        i_EXP_SUM
);

    localparam int unsigned SPAN = NREG << RAW;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t            state_q;
    logic              wait_q;
    logic [RAW-1:0]    prog_addr_q;
    logic [7:0]        prog_din_q;
    logic [NREG-1:0]   prog_cs_q;
    logic              prog_wr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [AW-1:0]     count_q;
    logic              end_pend_q;

    // Offset from BASE with a borrow bit so addresses below BASE fall out of range.
    logic [32:0]       diff_c;
    logic              in_range_c;
    logic [2:0]        reg_idx_c;
    logic [NREG-1:0]   cs_c;
    logic [AW-1:0]     count_d;
    logic              write_done_c;
    logic              load_done_c;

    assign diff_c     = {1'b0, 32'(i_DL_ADDR)} - 33'(BASE);
    assign in_range_c = !diff_c[32] && (diff_c[31:0] < SPAN);
    assign reg_idx_c  = diff_c[RAW+2:RAW];
    assign cs_c       = NREG'(1) << reg_idx_c;
    assign count_d    = count_q + AW'(1);

    // Completion conditions: end seen during/with the write, or plain end in LOAD.
    assign write_done_c = end_pend_q || i_DL_END;
    assign load_done_c  = i_DL_END && !(i_DL_WR && in_range_c);

`ifdef SALAMANDER_PROM_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    logic       chk_bad_c;

    assign sum_d = sum_q + prog_din_q;
    // Final sum is the post-write sum when finishing from WRITE.
    assign chk_bad_c = (state_q == WRITE) ? (write_done_c && (sum_d != i_EXP_SUM))
                                          : (load_done_c && (sum_q != i_EXP_SUM));
`else
    logic       chk_bad_c;
    logic       unused_exp_sum;

    assign chk_bad_c      = 1'b0;
    assign unused_exp_sum = ^i_EXP_SUM;
`endif

    // Loader FSM with registered outputs.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= IDLE;
            wait_q      <= 1'b0;
            prog_addr_q <= '0;
            prog_din_q  <= '0;
            prog_cs_q   <= '0;
            prog_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            end_pend_q  <= 1'b0;
`ifdef SALAMANDER_PROM_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_DL_START) begin
                        state_q    <= LOAD;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        count_q    <= '0;
                        end_pend_q <= 1'b0;
`ifdef SALAMANDER_PROM_CHECKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (i_DL_WR && in_range_c) begin
                        state_q     <= WRITE;
                        wait_q      <= 1'b1;
                        prog_wr_q   <= 1'b1;
                        prog_cs_q   <= cs_c;
                        prog_addr_q <= diff_c[RAW-1:0];
                        prog_din_q  <= i_DL_DATA;
                        end_pend_q  <= i_DL_END;
                    end else if (load_done_c) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= err_q | chk_bad_c;
                    end
                end
                WRITE: begin
                    wait_q     <= 1'b0;
                    prog_wr_q  <= 1'b0;
                    prog_cs_q  <= '0;
                    count_q    <= count_d;
                    end_pend_q <= 1'b0;
`ifdef SALAMANDER_PROM_CHECKSUM_EN
                    sum_q      <= sum_d;
`endif
                    // A strobe while waiting is dropped and flagged.
                    err_q <= err_q | i_DL_WR | chk_bad_c;
                    if (write_done_c) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_DL_WAIT   = wait_q;
    assign o_PROG_ADDR = prog_addr_q;
    assign o_PROG_DIN  = prog_din_q;
    assign o_PROG_CS   = prog_cs_q;
    assign o_PROG_WR   = prog_wr_q;
    assign o_BUSY      = busy_q;
    assign o_DONE      = done_q;
    assign o_ERR       = err_q;
    assign o_COUNT     = count_q;

endmodule

// File: tb/tb_salamander_prom_loader.sv
// Directed bench for salamander_prom_loader: per-cycle vector table plus
// hand sequences for reset during a write and the checksum option.
module tb_salamander_prom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl_start, dl_end, dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic [9:0]  prog_addr;
    logic [7:0]  prog_din;
    logic [3:0]  prog_cs;
    logic        prog_wr;
    logic        busy, done, err;
    logic [15:0] count;
    logic [7:0]  exp_sum;

    int n_chk = 0;
    int n_err = 0;

    salamander_prom_loader dut (
        .i_MCLK      (clk),
        .i_RST       (rst),
        .i_DL_START  (dl_start),
        .i_DL_END    (dl_end),
        .i_DL_WR     (dl_wr),
        .i_DL_ADDR   (dl_addr),
        .i_DL_DATA   (dl_data),
        .o_DL_WAIT   (dl_wait),
        .o_PROG_ADDR (prog_addr),
        .o_PROG_DIN  (prog_din),
        .o_PROG_CS   (prog_cs),
        .o_PROG_WR   (prog_wr),
        .o_BUSY      (busy),
        .o_DONE      (done),
        .o_ERR       (err),
        .o_COUNT     (count),
        .i_EXP_SUM   (exp_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s, e, w;
        logic [15:0] addr;
        logic [7:0]  data, sum;
        logic        x_wr;
        logic [3:0]  x_cs;
        logic [9:0]  x_addr;
        logic [7:0]  x_din;
        logic        x_wait, x_busy, x_done, x_err;
        logic [15:0] x_count;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic s, logic e, logic w, logic [15:0] a, logic [7:0] d,
                                logic [7:0] sm, logic xwr, logic [3:0] xcs, logic [9:0] xa,
                                logic [7:0] xd, logic xwt, logic xb, logic xdn, logic xer,
                                logic [15:0] xc);
        vec_t v;
        v.s = s; v.e = e; v.w = w; v.addr = a; v.data = d; v.sum = sm;
        v.x_wr = xwr; v.x_cs = xcs; v.x_addr = xa; v.x_din = xd;
        v.x_wait = xwt; v.x_busy = xb; v.x_done = xdn; v.x_err = xer; v.x_count = xc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic w,
                         input logic [15:0] a, input logic [7:0] d);
        dl_start = s; dl_end = e; dl_wr = w; dl_addr = a; dl_data = d;
    endtask

    // Status vector: {wr, cs, wait, busy, done, err, count}
    function automatic logic [63:0] status();
        return 64'({prog_wr, prog_cs, dl_wait, busy, done, err, count});
    endfunction

    function automatic logic [63:0] xstatus(logic xwr, logic [3:0] xcs, logic xwt, logic xb,
                                            logic xdn, logic xer, logic [15:0] xc);
        return 64'({xwr, xcs, xwt, xb, xdn, xer, xc});
    endfunction

    initial begin
        rst = 1'b1;
        exp_sum = 8'h00;
        drive(0, 0, 0, 16'h0, 8'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", status(), 64'h0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", status(), 64'h0);

        //          s e w addr     data  sum    wr cs  addr    din    wt b d er count
        // Two in-range bytes into regions 0 and 1, ignored START in LOAD, END, ignored END in DONE.
        vt.push_back(mk(1,0,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd0));
        vt.push_back(mk(0,0,1,16'h0000,8'h11,8'h33, 1,4'h1,10'h000,8'h11, 1,1,0,0,16'd0));
        vt.push_back(mk(0,0,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd1));
        vt.push_back(mk(0,0,1,16'h0401,8'h22,8'h33, 1,4'h2,10'h001,8'h22, 1,1,0,0,16'd1));
        vt.push_back(mk(0,0,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd2));
        vt.push_back(mk(1,0,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd2));
        vt.push_back(mk(0,1,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,0,1,0,16'd2));
        vt.push_back(mk(0,1,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,0,1,0,16'd2));
        // Out-of-range byte is discarded.
        vt.push_back(mk(1,0,0,16'h0000,8'h00,8'h00, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd0));
        vt.push_back(mk(0,0,1,16'h1000,8'hAA,8'h00, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd0));
        vt.push_back(mk(0,1,0,16'h0000,8'h00,8'h00, 0,4'h0,10'h000,8'h00, 0,0,1,0,16'd0));
        // Back-to-back strobes: second dropped, error sticky, START clears it.
        vt.push_back(mk(1,0,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd0));
        vt.push_back(mk(0,0,1,16'h0002,8'h33,8'h33, 1,4'h1,10'h002,8'h33, 1,1,0,0,16'd0));
        vt.push_back(mk(0,0,1,16'h0003,8'h44,8'h33, 0,4'h0,10'h000,8'h00, 0,1,0,1,16'd1));
        vt.push_back(mk(0,0,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,1,0,1,16'd1));
        vt.push_back(mk(0,1,0,16'h0000,8'h00,8'h33, 0,4'h0,10'h000,8'h00, 0,0,1,1,16'd1));
        // Write coincident with END into region 3.
        vt.push_back(mk(1,0,0,16'h0000,8'h00,8'h5A, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd0));
        vt.push_back(mk(0,1,1,16'h0C05,8'h5A,8'h5A, 1,4'h8,10'h005,8'h5A, 1,1,0,0,16'd0));
        vt.push_back(mk(0,0,0,16'h0000,8'h00,8'h5A, 0,4'h0,10'h000,8'h00, 0,0,1,0,16'd1));
        // END arriving during WRITE into region 2.
        vt.push_back(mk(1,0,0,16'h0000,8'h00,8'h01, 0,4'h0,10'h000,8'h00, 0,1,0,0,16'd0));
        vt.push_back(mk(0,0,1,16'h0805,8'h01,8'h01, 1,4'h4,10'h005,8'h01, 1,1,0,0,16'd0));
        vt.push_back(mk(0,1,0,16'h0000,8'h00,8'h01, 0,4'h0,10'h000,8'h00, 0,0,1,0,16'd1));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].s, vt[i].e, vt[i].w, vt[i].addr, vt[i].data);
            exp_sum = vt[i].sum;
            tick();
            check($sformatf("vec%0d_status", i), status(),
                  xstatus(vt[i].x_wr, vt[i].x_cs, vt[i].x_wait, vt[i].x_busy,
                          vt[i].x_done, vt[i].x_err, vt[i].x_count));
            if (vt[i].x_wr)
                check($sformatf("vec%0d_addr_din", i), 64'({prog_addr, prog_din}),
                      64'({vt[i].x_addr, vt[i].x_din}));
        end

        // Reset asserted mid-WRITE clears outputs without a clock edge.
        drive(1, 0, 0, 16'h0, 8'h0); tick();
        drive(0, 0, 1, 16'h0000, 8'h77); tick();
        drive(0, 0, 0, 16'h0, 8'h0);
        check("pre_reset_write", 64'({prog_wr, dl_wait, busy}), 64'(3'b111));
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", status(), 64'h0);
        #2 rst = 1'b0;
        tick();
        check("post_reset_idle", status(), 64'h0);
        drive(1, 0, 0, 16'h0, 8'h0); tick();
        check("restart_load", status(), xstatus(0, 4'h0, 0, 1, 0, 0, 16'd0));
        drive(0, 0, 1, 16'h0401, 8'h99); tick();
        check("restart_write", 64'({status(), prog_addr, prog_din}),
              64'({xstatus(1, 4'h2, 1, 1, 0, 0, 16'd0), 10'h001, 8'h99}));
        drive(0, 1, 0, 16'h0, 8'h0); exp_sum = 8'h99; tick();
        check("restart_done", status(), xstatus(0, 4'h0, 0, 0, 1, 0, 16'd1));

        // Checksum: 0x80 + 0x81 = 0x01 mod 256.
        for (int k = 0; k < 2; k++) begin
            logic x_err;
            drive(1, 0, 0, 16'h0, 8'h0); tick();
            drive(0, 0, 1, 16'h0000, 8'h80); tick();
            drive(0, 0, 0, 16'h0, 8'h0); tick();
            drive(0, 0, 1, 16'h0001, 8'h81); tick();
            drive(0, 0, 0, 16'h0, 8'h0); tick();
            exp_sum = (k == 0) ? 8'h01 : 8'h02;
`ifdef SALAMANDER_PROM_CHECKSUM_EN
            x_err = (k != 0);
`else
            x_err = 1'b0;
`endif
            drive(0, 1, 0, 16'h0, 8'h0); tick();
            check($sformatf("checksum_%0d", k), status(),
                  xstatus(0, 4'h0, 0, 0, 1, x_err, 16'd2));
        end

        drive(0, 0, 0, 16'h0, 8'h0);
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
